// File: rtl/tinyqv_pkg.sv
// Shared definitions for the TinyQV multi-word load/store sequencer.
package tinyqv_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    localparam int WORD_BYTES    = 4;
    localparam int MAX_EXTRA_OPS = 7;
endpackage

// File: rtl/tinyqv_mem_seq.sv
// Turns one decoded multi-word load/store into extra_ops+1 word transfers on
// consecutive addresses and registers, holding the core via busy meanwhile.
module tinyqv_mem_seq
    import tinyqv_pkg::*;
#(
    parameter int REG_ADDR_BITS = 4,
    parameter int ADDR_BITS     = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     start_ready,
    input  logic                     is_store,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [REG_ADDR_BITS-1:0] first_reg,
    input  logic [2:0]               extra_ops,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [ADDR_BITS-1:0]     mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ready,
    input  logic [31:0]              mem_rdata,
    output logic [REG_ADDR_BITS-1:0] rf_raddr,
    input  logic [31:0]              rf_rdata,
    output logic                     rf_wen,
    output logic [REG_ADDR_BITS-1:0] rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     misaligned
);
    state_e                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [REG_ADDR_BITS-1:0] reg_q, reg_d;
    logic [2:0]               rem_q, rem_d;
    logic                     is_store_q, is_store_d;
    logic                     done_q, done_d;
    logic                     misaligned_q, misaligned_d;

    logic start_seen, aligned, accept, xfer, last;

    assign start_seen = start && (state_q == IDLE);
    assign aligned    = (base_addr[1:0] == 2'b00);
    assign accept     = start_seen && aligned;
    assign xfer       = (state_q == REQ) && mem_ready;
    assign last       = xfer && (rem_q == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rst also squashes the write-back of a transfer completing on the reset edge
    always_comb begin
        start_ready = (state_q == IDLE);
        busy        = (state_q == REQ);
        mem_req     = (state_q == REQ);
        mem_write   = (state_q == REQ) && is_store_q;
        rf_wen      = xfer && !is_store_q && (reg_q != '0) && !rst;
    end

    assign mem_addr  = addr_q;
    assign rf_raddr  = reg_q;
    assign rf_waddr  = reg_q;
    assign mem_wdata = rf_rdata;
    assign rf_wdata  = mem_rdata;
    assign done       = done_q;
    assign misaligned = misaligned_q;

    always_comb begin
        addr_d       = addr_q;
        reg_d        = reg_q;
        rem_d        = rem_q;
        is_store_d   = is_store_q;
        done_d       = last;
        misaligned_d = start_seen && !aligned;
        if (accept) begin
            addr_d     = base_addr;
            reg_d      = first_reg;
            rem_d      = extra_ops;
            is_store_d = is_store;
        end else if (xfer) begin
            addr_d = addr_q + ADDR_BITS'(WORD_BYTES);
            reg_d  = reg_q + 1'b1;
            if (rem_q != 3'd0) rem_d = rem_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            reg_q        <= '0;
            rem_q        <= '0;
            is_store_q   <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            reg_q        <= reg_d;
            rem_q        <= rem_d;
            is_store_q   <= is_store_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
        end
    end
endmodule

// File: tb/tb_tinyqv_mem_seq.sv
// Self-checking bench for tinyqv_mem_seq: directed sequences plus randomized
// ones, each checked against a per-transfer list of expected addresses/registers.
module tb_tinyqv_mem_seq;
    logic        clk = 1'b0;
    logic        rst, start, is_store, mem_ready;
    logic [27:0] base_addr;
    logic [3:0]  first_reg;
    logic [2:0]  extra_ops;
    logic [31:0] mem_rdata, rf_rdata;
    logic        start_ready, mem_req, mem_write, rf_wen, busy, done, misaligned;
    logic [27:0] mem_addr;
    logic [31:0] mem_wdata, rf_wdata;
    logic [3:0]  rf_raddr, rf_waddr;

    int n_chk = 0;
    int n_err = 0;

    tinyqv_mem_seq #(.REG_ADDR_BITS(4), .ADDR_BITS(28)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .is_store(is_store), .base_addr(base_addr), .first_reg(first_reg),
        .extra_ops(extra_ops), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; drives start there, so consecutive calls exercise a
    // start on the done cycle. Returns at the negedge of the done cycle.
    task automatic run_seq(input bit st, input logic [27:0] base, input logic [3:0] fr,
                           input logic [2:0] ex, input int rdy_pct, input bit hold,
                           input int fixed_delay);
        int          nwen, exp_wen, waited;
        bit          ready, wen_exp;
        logic [27:0] exp_a;
        logic [3:0]  exp_r;
        start = 1'b1; is_store = st; base_addr = base; first_reg = fr; extra_ops = ex;
        mem_ready = 1'b0;
        #1 chk("start_ready_at_start", start_ready, 1);
        tick();
        if (!hold) start = 1'b0;
        nwen = 0; exp_wen = 0;
        for (int i = 0; i <= int'(ex); i++) begin
            exp_a = base + 28'(4 * i);
            exp_r = fr + 4'(i);
            if (!st && exp_r != 4'd0) exp_wen++;
            waited = 0;
            do begin
                if (hold) begin
                    base_addr = 28'($urandom); first_reg = 4'($urandom);
                    extra_ops = 3'($urandom); is_store = 1'($urandom);
                end
                if (fixed_delay >= 0) ready = (waited >= fixed_delay);
                else ready = ($urandom_range(99) < rdy_pct) || (waited >= 10);
                mem_ready = ready;
                mem_rdata = $urandom; rf_rdata = $urandom;
                #1;
                wen_exp = ready && !st && (exp_r != 4'd0);
                chk("mem_req",    mem_req, 1);
                chk("mem_addr",   mem_addr, exp_a);
                chk("mem_write",  mem_write, st);
                chk("rf_raddr",   rf_raddr, exp_r);
                chk("busy",       busy, 1);
                chk("start_ready_busy", start_ready, 0);
                chk("done_busy",  done, 0);
                chk("misaligned_busy", misaligned, 0);
                chk("mem_wdata",  mem_wdata, rf_rdata);
                chk("rf_wdata",   rf_wdata, mem_rdata);
                chk("rf_wen",     rf_wen, wen_exp);
                if (wen_exp) begin
                    chk("rf_waddr", rf_waddr, exp_r);
                    nwen++;
                end
                tick();
                waited++;
            end while (!ready);
        end
        mem_ready = 1'b0;
        start = 1'b0;
        #1;
        chk("done_pulse",      done, 1);
        chk("busy_end",        busy, 0);
        chk("start_ready_end", start_ready, 1);
        chk("mem_req_end",     mem_req, 0);
        chk("wen_count",       nwen, exp_wen);
    endtask

    task automatic idle(input int n);
        start = 1'b0; mem_ready = 1'b0;
        repeat (n) begin
            tick();
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_req",  mem_req, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; mem_ready = 1'b0;
        base_addr = '0; first_reg = '0; extra_ops = '0; mem_rdata = '0; rf_rdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_reg", rf_raddr, 0);
        rst = 1'b0;
        idle(1);

        run_seq(1'b0, 28'h100, 4'd8, 3'd3, 100, 1'b0, -1);
        idle(1);
        run_seq(1'b1, 28'h2000, 4'd9, 3'd0, 100, 1'b0, 3);
        idle(2);
        run_seq(1'b0, 28'h300, 4'd14, 3'd2, 100, 1'b0, -1);
        idle(1);

        // misaligned start is rejected with a one-cycle pulse
        start = 1'b1; is_store = 1'b0; base_addr = 28'h102; first_reg = 4'd3; extra_ops = 3'd1;
        tick();
        start = 1'b0;
        #1;
        chk("misaligned_pulse", misaligned, 1);
        chk("misaligned_busy0", busy, 0);
        chk("misaligned_req0",  mem_req, 0);
        tick();
        chk("misaligned_clear", misaligned, 0);
        chk("misaligned_req1",  mem_req, 0);

        // reset during the 2nd of 8 transfers
        start = 1'b1; is_store = 1'b0; base_addr = 28'h400; first_reg = 4'd1; extra_ops = 3'd7;
        tick();
        start = 1'b0; mem_ready = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_addr", mem_addr, 28'h404);
        chk("rst_mid_wen",  rf_wen, 0);
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req",  mem_req, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ready", start_ready, 1);
        tick();
        chk("rst_mid_done2", done, 0);
        run_seq(1'b0, 28'h500, 4'd2, 3'd1, 100, 1'b0, -1);

        // start held high throughout, chained back-to-back on done cycles
        run_seq(1'b1, 28'h600, 4'd5, 3'd2, 60, 1'b1, -1);
        run_seq(1'b0, 28'h700, 4'd6, 3'd4, 60, 1'b1, -1);
        run_seq(1'b0, 28'hFFFFFF8, 4'd15, 3'd3, 100, 1'b0, -1);
        idle(1);

        for (int k = 0; k < 20; k++) begin
            run_seq(1'($urandom), {26'($urandom), 2'b00}, 4'($urandom), 3'($urandom),
                    $urandom_range(100, 30), 1'($urandom), -1);
            if ($urandom_range(1)) idle($urandom_range(2, 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
